// File: rtl/aes_block_gearbox_pkg.sv
// Shared constants and FSM state type for the AES block gearbox.
package aes_package;

  localparam int AES_BLK_W         = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = 4;

  typedef enum logic [1:0] {
    AES_GBX_IDLE,
    AES_GBX_ACTIVE,
    AES_GBX_DONE
  } aes_gbx_state_t;

endpackage

// File: rtl/aes_word_unpacker.sv
// Holds one 128-bit ciphertext block and emits it as four 32-bit words, word 0 = bits [127:96].
// Block accepted at edge t gives word 0 valid after t; ready refills on the last-word drain.
module aes_word_unpacker
  import aes_package::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load_i,
  input  logic [CNT_W-1:0]      nblocks_i,
  input  logic                  active_i,
  input  logic                  ct_valid_i,
  output logic                  ct_ready_o,
  input  logic [AES_BLK_W-1:0]  ct_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [AES_WORD_W-1:0] out_data_o,
  output logic [3:0]            out_strb_o,
  output logic                  rem_zero_o
);

  logic [AES_BLK_W-1:0] hold_q;
  logic [1:0]           up_idx;
  logic [CNT_W-1:0]     up_rem;
  logic                 out_vld_q;
  logic                 ct_fire;
  logic                 out_fire;
  logic                 last_word;

  assign last_word  = (up_idx == 2'd3);
  assign ct_ready_o = active_i && (up_rem != '0) &&
                      (!out_vld_q || (last_word && out_ready_i));
  assign ct_fire    = ct_valid_i && ct_ready_o;
  assign out_fire   = out_vld_q && out_ready_i;
  assign rem_zero_o = (up_rem == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hold_q    <= '0;
      up_idx    <= '0;
      up_rem    <= '0;
      out_vld_q <= 1'b0;
    end else if (load_i) begin
      up_rem <= nblocks_i;
      up_idx <= '0;
    end else if (ct_fire) begin
      // A new block may land on the same edge the last word of the previous one drains.
      hold_q    <= ct_data_i;
      up_idx    <= '0;
      out_vld_q <= 1'b1;
      up_rem    <= up_rem - 1'b1;
    end else if (out_fire) begin
      up_idx <= up_idx + 2'd1;
      if (last_word) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  always_comb begin
    out_data_o = '0;
    case (up_idx)
      2'd0:    out_data_o = hold_q[127:96];
      2'd1:    out_data_o = hold_q[95:64];
      2'd2:    out_data_o = hold_q[63:32];
      default: out_data_o = hold_q[31:0];
    endcase
  end

  assign out_valid_o = out_vld_q;
  assign out_strb_o  = out_vld_q ? 4'hF : 4'h0;

endmodule

// File: rtl/aes_block_gearbox.sv
// Packs 32-bit plaintext words into 128-bit AES blocks and unpacks ciphertext blocks back to words.
// One-cycle latency each way, 1 word/cycle sustained; input readies follow downstream readies.
module aes_block_gearbox
  import aes_package::*;
#(
  parameter int WORD_W = 32,
  parameter int BLK_W  = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  nblocks_i,
  input  logic              pt_valid_i,
  output logic              pt_ready_o,
  input  logic [WORD_W-1:0] pt_data_i,
  input  logic [3:0]        pt_strb_i,
  output logic              blk_valid_o,
  input  logic              blk_ready_i,
  output logic [BLK_W-1:0]  blk_data_o,
  input  logic              ct_valid_i,
  output logic              ct_ready_o,
  input  logic [BLK_W-1:0]  ct_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic [3:0]        out_strb_o,
  output logic              done_o,
  output logic              strb_err_o,
  output logic              busy_o
);

  aes_gbx_state_t state_q, state_d;

  logic [CNT_W-1:0]    pk_rem;
  logic [1:0]          pk_idx;
  logic [3*WORD_W-1:0] acc_q;
  logic [BLK_W-1:0]    blk_q;
  logic                blk_vld_q;
  logic                strb_err_q;
  logic                active;
  logic                start_acc;
  logic                pt_fire;
  logic                blk_fire;
  logic                up_rem_zero;
  logic                drained;

  assign active    = (state_q == AES_GBX_ACTIVE);
  assign start_acc = (state_q == AES_GBX_IDLE) && start_i;

  // The fourth word may enter while the held block drains on the same edge.
  assign pt_ready_o = active && (pk_rem != '0) &&
                      ((pk_idx != 2'd3) || !blk_vld_q || blk_ready_i);
  assign pt_fire    = pt_valid_i && pt_ready_o;
  assign blk_fire   = blk_vld_q && blk_ready_i;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pk_rem     <= '0;
      pk_idx     <= '0;
      acc_q      <= '0;
      blk_q      <= '0;
      blk_vld_q  <= 1'b0;
      strb_err_q <= 1'b0;
    end else if (start_acc) begin
      pk_rem     <= nblocks_i;
      pk_idx     <= '0;
      strb_err_q <= 1'b0;
    end else begin
      if (pt_fire) begin
        pk_idx <= pk_idx + 2'd1;
        if (pt_strb_i != 4'hF) begin
          strb_err_q <= 1'b1;
        end
        if (pk_idx == 2'd3) begin
          blk_q  <= {acc_q, pt_data_i};
          pk_rem <= pk_rem - 1'b1;
        end else begin
          acc_q <= {acc_q[2*WORD_W-1:0], pt_data_i};
        end
      end
      if (pt_fire && (pk_idx == 2'd3)) begin
        blk_vld_q <= 1'b1;
      end else if (blk_fire) begin
        blk_vld_q <= 1'b0;
      end
    end
  end

  assign blk_valid_o = blk_vld_q;
  assign blk_data_o  = blk_q;
  assign strb_err_o  = strb_err_q;

  aes_word_unpacker #(
    .CNT_W (CNT_W)
  ) u_unpacker (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .load_i      (start_acc),
    .nblocks_i   (nblocks_i),
    .active_i    (active),
    .ct_valid_i  (ct_valid_i),
    .ct_ready_o  (ct_ready_o),
    .ct_data_i   (ct_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .rem_zero_o  (up_rem_zero)
  );

  assign drained = (pk_rem == '0) && up_rem_zero && !blk_vld_q && !out_valid_o;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= AES_GBX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AES_GBX_IDLE: begin
        if (start_i) begin
          state_d = (nblocks_i != '0) ? AES_GBX_ACTIVE : AES_GBX_DONE;
        end
      end
      AES_GBX_ACTIVE: begin
        if (drained) begin
          state_d = AES_GBX_DONE;
        end
      end
      AES_GBX_DONE: state_d = AES_GBX_IDLE;
      default:      state_d = AES_GBX_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == AES_GBX_ACTIVE);
    done_o = (state_q == AES_GBX_DONE);
  end

endmodule
